// File: rtl/uart_cmd_decoder.sv
// Assembles UART bytes into 8-byte XOR-checked draw commands and presents them
// over a valid/ready handshake, with single-cycle checksum/overrun/timeout pulses.
module uart_cmd_decoder #(
  parameter int unsigned X_W     = 10,
  parameter int unsigned Y_W     = 10,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [8:0]     frame,
  input  logic           frame_valid,
  input  logic           cmd_ready,
  output logic           cmd_valid,
  output logic [1:0]     cmd_op,
  output logic [X_W-1:0] cmd_x,
  output logic [Y_W-1:0] cmd_y,
  output logic [7:0]     cmd_color,
  output logic           err_checksum,
  output logic           err_overrun,
  output logic           err_timeout,
  output logic           busy
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      Sync    = 8'hA5;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StHunt, StOp, StXh, StXl, StYh, StYl, StCol, StChk
  } state_e;

  state_e          state_q;
  logic            fv_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      acc_q;
  logic [1:0]      op_q;
  logic [15:0]     x_q;
  logic [15:0]     y_q;
  logic [7:0]      col_q;

  logic [7:0] data;
  logic       byte_stb;
  logic       in_pkt;
  logic       expire;
  logic       chk_stb;
  logic       chk_ok;
  logic       load;

  assign data     = frame[7:0];
  assign byte_stb = frame_valid & ~fv_q;
  assign in_pkt   = (state_q != StHunt);
  // Expiry is taken on the edge where the counter would reach TIMEOUT; a byte wins.
  assign expire   = in_pkt & ~byte_stb & (cnt_q == CntLast);
  assign chk_stb  = byte_stb & (state_q == StChk);
  assign chk_ok   = (data == acc_q);
  assign load     = chk_stb & chk_ok & (~cmd_valid | cmd_ready);
  assign busy     = in_pkt;

  // frame[8] and the coordinate bits above X_W/Y_W are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{frame[8], x_q[15:X_W], y_q[15:Y_W]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StHunt;
      fv_q         <= 1'b1;
      cnt_q        <= '0;
      acc_q        <= '0;
      op_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      col_q        <= '0;
      cmd_valid    <= 1'b0;
      cmd_op       <= '0;
      cmd_x        <= '0;
      cmd_y        <= '0;
      cmd_color    <= '0;
      err_checksum <= 1'b0;
      err_overrun  <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      fv_q         <= frame_valid;
      err_checksum <= 1'b0;
      err_overrun  <= 1'b0;
      err_timeout  <= 1'b0;

      if (!in_pkt || byte_stb || expire) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end

      if (byte_stb) begin
        unique case (state_q)
          StHunt: begin
            if (data == Sync) begin
              state_q <= StOp;
              acc_q   <= '0;
            end
          end
          StOp: begin
            op_q    <= data[1:0];
            acc_q   <= acc_q ^ data;
            state_q <= StXh;
          end
          StXh: begin
            x_q[15:8] <= data;
            acc_q     <= acc_q ^ data;
            state_q   <= StXl;
          end
          StXl: begin
            x_q[7:0] <= data;
            acc_q    <= acc_q ^ data;
            state_q  <= StYh;
          end
          StYh: begin
            y_q[15:8] <= data;
            acc_q     <= acc_q ^ data;
            state_q   <= StYl;
          end
          StYl: begin
            y_q[7:0] <= data;
            acc_q    <= acc_q ^ data;
            state_q  <= StCol;
          end
          StCol: begin
            col_q   <= data;
            acc_q   <= acc_q ^ data;
            state_q <= StChk;
          end
          StChk: begin
            state_q <= StHunt;
            if (!chk_ok) begin
              err_checksum <= 1'b1;
            end else if (cmd_valid && !cmd_ready) begin
              err_overrun <= 1'b1;
            end
          end
          default: state_q <= StHunt;
        endcase
      end else if (expire) begin
        state_q     <= StHunt;
        err_timeout <= 1'b1;
      end

      // A completing packet overrides the accept so back-to-back commands never gap.
      if (load) begin
        cmd_valid <= 1'b1;
        cmd_op    <= op_q;
        cmd_x     <= x_q[X_W-1:0];
        cmd_y     <= y_q[Y_W-1:0];
        cmd_color <= col_q;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomised bench for uart_cmd_decoder: byte streams are parsed by a packet-level
// model and compared against commands and error pulses observed at the DUT.
module tb_uart_cmd_decoder;

  typedef logic [29:0] cmd_t;  // {op, x, y, color}

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [8:0] frame = 9'h0A5;
  logic       frame_valid = 1'b1;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [9:0] cmd_x;
  logic [9:0] cmd_y;
  logic [7:0] cmd_color;
  logic       err_checksum;
  logic       err_overrun;
  logic       err_timeout;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int   n_chk = 0;
  int   n_ovr = 0;
  int   n_tmo = 0;
  cmd_t got_cmds[$];

  logic [7:0] tx[$];
  cmd_t       exp_cmds[$];
  int         exp_bad;

  uart_cmd_decoder #(
    .X_W    (10),
    .Y_W    (10),
    .TIMEOUT(50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame       (frame),
    .frame_valid (frame_valid),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_color   (cmd_color),
    .err_checksum(err_checksum),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Observer: accepted commands and error-pulse cycles.
  always @(negedge clk) begin
    if (rst) begin
      if (cmd_valid && cmd_ready) got_cmds.push_back({cmd_op, cmd_x, cmd_y, cmd_color});
      if (err_checksum) n_chk++;
      if (err_overrun) n_ovr++;
      if (err_timeout) n_tmo++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    logic b8;
    b8 = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    frame       = {b8, b};
    frame_valid = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
  endtask

  task automatic send_stream(input int gap_max);
    for (int i = 0; i < tx.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) @(posedge clk);
      send_byte(tx[i]);
    end
    tx.delete();
  endtask

  task automatic push_pkt(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y,
                          input logic [7:0] col, input bit corrupt);
    logic [7:0] chk;
    chk = op ^ x[15:8] ^ x[7:0] ^ y[15:8] ^ y[7:0] ^ col;
    if (corrupt) chk = chk ^ (8'h01 << $urandom_range(0, 7));
    tx.push_back(8'hA5);
    tx.push_back(op);
    tx.push_back(x[15:8]);
    tx.push_back(x[7:0]);
    tx.push_back(y[15:8]);
    tx.push_back(y[7:0]);
    tx.push_back(col);
    tx.push_back(chk);
  endtask

  // Packet-level reference: scan for sync, take 7 bytes, XOR-check, emit command or error.
  task automatic model_parse();
    int         i;
    logic [7:0] s;
    logic [7:0] op8;
    logic [15:0] x16;
    logic [15:0] y16;
    exp_cmds.delete();
    exp_bad = 0;
    i = 0;
    while (i < tx.size()) begin
      if (tx[i] == 8'hA5 && i + 7 < tx.size()) begin
        s = 8'h00;
        for (int k = 1; k <= 6; k++) s = s ^ tx[i + k];
        if (s == tx[i + 7]) begin
          op8 = tx[i + 1];
          x16 = {tx[i + 2], tx[i + 3]};
          y16 = {tx[i + 4], tx[i + 5]};
          exp_cmds.push_back({op8[1:0], x16[9:0], y16[9:0], tx[i + 6]});
        end else begin
          exp_bad++;
        end
        i += 8;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({cmd_valid, busy, err_checksum, err_overrun, err_timeout} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 00000",
                         {cmd_valid, busy, err_checksum, err_overrun, err_timeout}); end
    checks++; if ({cmd_op, cmd_x, cmd_y, cmd_color} !== 30'h0) begin
      errors++; $display("FAIL reset_data: got %h required 0", {cmd_op, cmd_x, cmd_y, cmd_color});
    end
    #2 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_phantom_byte: busy got %b required 0", busy); end
    frame_valid = 1'b0;
  endtask

  task automatic test_good_packet();
    int   base = got_cmds.size();
    int   c0 = n_chk, o0 = n_ovr, t0 = n_tmo;
    cmd_t want = {2'd1, 10'd319, 10'd240, 8'hE3};
    cmd_ready = 1'b1;
    tx = '{8'hA5, 8'h01, 8'h01, 8'h3F, 8'h00, 8'hF0, 8'hE3, 8'h2C};
    send_stream(2);
    checks++; if (cmd_valid !== 1'b1) begin
      errors++; $display("FAIL good_latency: cmd_valid got %b required 1", cmd_valid); end
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL good_busy_after: got %b required 0", busy); end
    @(posedge clk); #1;
    checks++; if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL good_valid_drop: got %b required 0", cmd_valid); end
    checks++; if (got_cmds.size() !== base + 1) begin
      errors++; $display("FAIL good_count: got %0d required %0d", got_cmds.size(), base + 1);
    end else begin
      checks++; if (got_cmds[base] !== want) begin
        errors++; $display("FAIL good_data: got %h required %h", got_cmds[base], want); end
    end
    checks++; if ({n_chk - c0, n_ovr - o0, n_tmo - t0} !== {32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL good_no_err: got chk=%0d ovr=%0d tmo=%0d required 0",
                         n_chk - c0, n_ovr - o0, n_tmo - t0); end
  endtask

  task automatic test_bad_checksum();
    int   base = got_cmds.size();
    int   c0 = n_chk;
    cmd_t want = {2'd1, 10'd319, 10'd240, 8'hE3};
    cmd_ready = 1'b1;
    tx = '{8'hA5, 8'h01, 8'h01, 8'h3F, 8'h00, 8'hF0, 8'hE3, 8'h2D};
    send_stream(1);
    repeat (3) @(posedge clk); #1;
    checks++; if (n_chk - c0 !== 1) begin
      errors++; $display("FAIL bad_chk_pulse: got %0d cycles required 1", n_chk - c0); end
    checks++; if (got_cmds.size() !== base || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL bad_chk_no_cmd: got %0d cmds valid=%b required 0",
                         got_cmds.size() - base, cmd_valid); end
    tx = '{8'hA5, 8'h01, 8'h01, 8'h3F, 8'h00, 8'hF0, 8'hE3, 8'h2C};
    send_stream(1);
    @(posedge clk); #1;
    checks++; if (got_cmds.size() !== base + 1 || got_cmds[got_cmds.size() - 1] !== want) begin
      errors++; $display("FAIL bad_chk_recover: got %0d cmds required 1 matching %h",
                         got_cmds.size() - base, want); end
  endtask

  task automatic test_junk();
    int   base = got_cmds.size();
    cmd_t want = {2'd1, 10'd319, 10'd240, 8'hE3};
    logic [7:0] junk[3] = '{8'h00, 8'hFF, 8'h5A};
    logic [7:0] pkt[8] = '{8'hA5, 8'h01, 8'h01, 8'h3F, 8'h00, 8'hF0, 8'hE3, 8'h2C};
    cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_byte(junk[i]);
      checks++; if (busy !== 1'b0) begin
        errors++; $display("FAIL junk_busy[%0d]: got %b required 0", i, busy); end
    end
    send_byte(pkt[0]);
    checks++; if (busy !== 1'b1) begin
      errors++; $display("FAIL junk_sync_busy: got %b required 1", busy); end
    for (int i = 1; i < 8; i++) send_byte(pkt[i]);
    @(posedge clk); #1;
    checks++; if (got_cmds.size() !== base + 1 || got_cmds[got_cmds.size() - 1] !== want) begin
      errors++; $display("FAIL junk_decode: got %0d cmds required 1 matching %h",
                         got_cmds.size() - base, want); end
  endtask

  task automatic test_overrun_back_to_back();
    int          base = got_cmds.size();
    int          o0 = n_ovr;
    cmd_t        first = {2'd1, 10'd319, 10'd240, 8'hE3};
    cmd_t        third;
    logic [7:0]  op3 = 8'($urandom_range(0, 255));
    logic [15:0] x3 = 16'($urandom_range(0, 65535));
    logic [15:0] y3 = 16'($urandom_range(0, 65535));
    logic [7:0]  c3 = 8'($urandom_range(0, 255));
    third = {op3[1:0], x3[9:0], y3[9:0], c3};
    cmd_ready = 1'b0;
    tx = '{8'hA5, 8'h01, 8'h01, 8'h3F, 8'h00, 8'hF0, 8'hE3, 8'h2C};
    send_stream(1);
    push_pkt(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)),
             16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), 1'b0);
    send_stream(1);
    repeat (2) @(posedge clk); #1;
    checks++; if (n_ovr - o0 !== 1) begin
      errors++; $display("FAIL ovr_pulse: got %0d cycles required 1", n_ovr - o0); end
    checks++; if ({cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color} !== {1'b1, first}) begin
      errors++; $display("FAIL ovr_hold: got %h required %h",
                         {cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color}, {1'b1, first}); end
    push_pkt(op3, x3, y3, c3, 1'b0);
    for (int i = 0; i < 7; i++) send_byte(tx[i]);
    @(posedge clk); #1;
    frame       = {1'b0, tx[7]};
    frame_valid = 1'b1;
    cmd_ready   = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    cmd_ready   = 1'b0;
    tx.delete();
    checks++; if ({cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color} !== {1'b1, third}) begin
      errors++; $display("FAIL b2b_load: got %h required %h",
                         {cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color}, {1'b1, third}); end
    checks++; if (n_ovr - o0 !== 1) begin
      errors++; $display("FAIL b2b_no_ovr: got %0d required 1", n_ovr - o0); end
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: cmd_valid got %b required 0", cmd_valid); end
    checks++; if (got_cmds.size() !== base + 2 || got_cmds[base] !== first
                  || got_cmds[base + 1] !== third) begin
      errors++; $display("FAIL b2b_accepts: got %0d accepts required 2 (%h, %h)",
                         got_cmds.size() - base, first, third); end
  endtask

  task automatic test_timeout();
    int   t0 = n_tmo;
    int   first = -1;
    logic busy49 = 1'b0;
    int   base;
    cmd_t want = {2'd1, 10'd319, 10'd240, 8'hE3};
    logic [7:0] rest[6] = '{8'h01, 8'h3F, 8'h00, 8'hF0, 8'hE3, 8'h2C};
    cmd_ready = 1'b1;
    tx = '{8'hA5, 8'h01, 8'h01};
    send_stream(2);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == 49) busy49 = busy;
      if (err_timeout && first < 0) first = n;
    end
    checks++; if (first !== 50) begin
      errors++; $display("FAIL tmo_time: pulse at idle clk %0d required 50", first); end
    checks++; if (n_tmo - t0 !== 1 || busy49 !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL tmo_pulse_busy: got %0d cycles busy49=%b busy=%b required 1 1 0",
                         n_tmo - t0, busy49, busy); end
    // Byte landing in the expiry cycle must keep the packet alive.
    base = got_cmds.size();
    t0 = n_tmo;
    send_byte(8'hA5);
    repeat (48) @(posedge clk);
    send_byte(8'h01);
    checks++; if (n_tmo - t0 !== 0 || busy !== 1'b1) begin
      errors++; $display("FAIL tmo_byte_wins: got %0d pulses busy=%b required 0 1",
                         n_tmo - t0, busy); end
    for (int i = 0; i < 6; i++) send_byte(rest[i]);
    @(posedge clk); #1;
    checks++; if (got_cmds.size() !== base + 1 || got_cmds[got_cmds.size() - 1] !== want) begin
      errors++; $display("FAIL tmo_recover: got %0d cmds required 1 matching %h",
                         got_cmds.size() - base, want); end
  endtask

  task automatic test_reset_mid_packet();
    int   base;
    cmd_ready = 1'b0;
    push_pkt(8'($urandom_range(0, 255)), 16'($urandom_range(1, 65535)),
             16'($urandom_range(0, 65535)), 8'($urandom_range(1, 255)), 1'b0);
    send_stream(1);
    tx = '{8'hA5, 8'h01, 8'h02, 8'h03};
    send_stream(1);
    #2;
    rst         = 1'b0;
    frame       = 9'h0A5;
    frame_valid = 1'b1;
    #1;
    checks++; if ({cmd_valid, busy, err_checksum, err_overrun, err_timeout, cmd_op, cmd_x, cmd_y,
                   cmd_color} !== 35'h0) begin
      errors++; $display("FAIL midrst_zero: got %h required 0", {cmd_valid, busy, err_checksum,
                         err_overrun, err_timeout, cmd_op, cmd_x, cmd_y, cmd_color}); end
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (4) @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_phantom: busy=%b valid=%b required 0 0", busy, cmd_valid); end
    frame_valid = 1'b0;
    cmd_ready   = 1'b1;
    base = got_cmds.size();
    push_pkt(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)),
             16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)), 1'b0);
    model_parse();
    send_stream(2);
    @(posedge clk); #1;
    checks++; if (got_cmds.size() !== base + 1 || got_cmds[got_cmds.size() - 1] !== exp_cmds[0])
    begin
      errors++; $display("FAIL midrst_recover: got %0d cmds required 1 matching %h",
                         got_cmds.size() - base, exp_cmds[0]); end
  endtask

  task automatic test_random();
    int         base = got_cmds.size();
    int         c0 = n_chk, o0 = n_ovr, t0 = n_tmo;
    logic [7:0] b;
    cmd_ready = 1'b1;
    tx.delete();
    for (int p = 0; p < 20; p++) begin
      repeat ($urandom_range(0, 2)) begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'hA5);
        tx.push_back(b);
      end
      push_pkt(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)),
               16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255)),
               ($urandom_range(0, 3) == 0));
    end
    model_parse();
    send_stream(3);
    repeat (4) @(posedge clk); #1;
    checks++; if (got_cmds.size() - base !== exp_cmds.size()) begin
      errors++; $display("FAIL rand_count: got %0d cmds required %0d",
                         got_cmds.size() - base, exp_cmds.size());
    end else begin
      for (int i = 0; i < exp_cmds.size(); i++) begin
        checks++; if (got_cmds[base + i] !== exp_cmds[i]) begin
          errors++; $display("FAIL rand_cmd[%0d]: got %h required %h", i, got_cmds[base + i],
                             exp_cmds[i]); end
      end
    end
    checks++; if (n_chk - c0 !== exp_bad || n_ovr !== o0 || n_tmo !== t0) begin
      errors++; $display("FAIL rand_errs: got chk=%0d ovr=%0d tmo=%0d required %0d 0 0",
                         n_chk - c0, n_ovr - o0, n_tmo - t0, exp_bad); end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_junk();
    test_overrun_back_to_back();
    test_timeout();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
